// File: rtl/collision_probe.sv
// Edge-probe collision scanner: snapshots the player box, reads eight probe tiles from the
// tile-map ROM and commits {up, down, left, right} blocked flags once per 10-cycle scan.
module collision_probe #(
   parameter int unsigned PLAYER_W   = 32,
   parameter int unsigned PLAYER_H   = 32,
   parameter int unsigned SCREEN_W   = 800,
   parameter int unsigned SCREEN_H   = 600,
   parameter int unsigned TILE_SHIFT = 5,
   parameter int unsigned MAP_COLS   = 25,
   parameter int unsigned ADDR_W     = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   output logic              map_rd_en,
   output logic [ADDR_W-1:0] map_addr,
   input  logic              map_data,
   output logic [3:0]        is_collide,
   output logic              scan_done
);

   localparam logic [10:0] WM1 = 11'(PLAYER_W - 1);
   localparam logic [10:0] WP  = 11'(PLAYER_W);
   localparam logic [10:0] HM1 = 11'(PLAYER_H - 1);
   localparam logic [10:0] HP  = 11'(PLAYER_H);
   localparam logic [10:0] SW  = 11'(SCREEN_W);
   localparam logic [10:0] SH  = 11'(SCREEN_H);

   typedef enum logic [1:0] {StIdle, StSnap, StProbe, StCollect} state_e;

   state_e            state_q, state_d;
   logic [10:0]       snap_x_q, snap_x_d, snap_y_q, snap_y_d;
   logic [2:0]        k_q, k_d;
   logic [3:0]        acc_q, acc_d, collide_q, collide_d;
   logic              done_q, done_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              oob1_q, oob1_d, vld1_q, vld1_d;
   logic [1:0]        dir1_q, dir1_d;
   logic              oob2_q, vld2_q;
   logic [1:0]        dir2_q;

   logic              issue, oob;
   logic [2:0]        idx;
   logic [10:0]       src_x, src_y, px, py;
   logic [3:0]        hit_vec, acc_sum;

   // The read for probe idx is registered, so it is computed one cycle ahead; in SNAP the
   // snapshot is not yet loaded, so probe 0 comes straight from the position inputs.
   always_comb begin
      src_x = (state_q == StSnap) ? {1'b0, pos_x} : snap_x_q;
      src_y = (state_q == StSnap) ? {1'b0, pos_y} : snap_y_q;
      issue = (state_q == StSnap) || ((state_q == StProbe) && (k_q != 3'd7));
      idx   = (state_q == StSnap) ? 3'd0 : k_q + 3'd1;
      px    = src_x;
      py    = src_y;
      case (idx)
         3'd0:    py = src_y - 11'd1;
         3'd1:    begin px = src_x + WM1; py = src_y - 11'd1; end
         3'd2:    py = src_y + HP;
         3'd3:    begin px = src_x + WM1; py = src_y + HP;    end
         3'd4:    px = src_x - 11'd1;
         3'd5:    begin px = src_x - 11'd1; py = src_y + HM1; end
         3'd6:    px = src_x + WP;
         default: begin px = src_x + WP;    py = src_y + HM1; end
      endcase
      // Unsigned compare also catches the wrapped X-1 / Y-1 at the top-left edge.
      oob     = (px >= SW) || (py >= SH);
      rd_en_d = issue && !oob;
      addr_d  = rd_en_d ? ADDR_W'(32'(py >> TILE_SHIFT) * MAP_COLS + 32'(px >> TILE_SHIFT))
                        : '0;
      oob1_d  = issue && oob;
      vld1_d  = issue;
      dir1_d  = idx[2:1];
   end

   assign hit_vec = (vld2_q && (map_data || oob2_q)) ? (4'b1000 >> dir2_q) : 4'b0000;
   assign acc_sum = acc_q | hit_vec;

   always_comb begin
      state_d   = state_q;
      snap_x_d  = snap_x_q;
      snap_y_d  = snap_y_q;
      k_d       = k_q;
      acc_d     = acc_sum;
      collide_d = collide_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StSnap;
         end
         StSnap: begin
            snap_x_d = {1'b0, pos_x};
            snap_y_d = {1'b0, pos_y};
            k_d      = 3'd0;
            acc_d    = 4'b0000;
            state_d  = StProbe;
         end
         StProbe: begin
            if (k_q == 3'd7) state_d = StCollect;
            else             k_d     = k_q + 3'd1;
         end
         StCollect: begin
            collide_d = acc_sum;
            done_d    = 1'b1;
            state_d   = enable ? StSnap : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         snap_x_q  <= '0;
         snap_y_q  <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         collide_q <= '0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         addr_q    <= '0;
         oob1_q    <= 1'b0;
         vld1_q    <= 1'b0;
         dir1_q    <= '0;
         oob2_q    <= 1'b0;
         vld2_q    <= 1'b0;
         dir2_q    <= '0;
      end else begin
         state_q   <= state_d;
         snap_x_q  <= snap_x_d;
         snap_y_q  <= snap_y_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
         collide_q <= collide_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         addr_q    <= addr_d;
         oob1_q    <= oob1_d;
         vld1_q    <= vld1_d;
         dir1_q    <= dir1_d;
         oob2_q    <= oob1_q;
         vld2_q    <= vld1_q;
         dir2_q    <= dir1_q;
      end
   end

   assign map_rd_en  = rd_en_q;
   assign map_addr   = addr_q;
   assign is_collide = collide_q;
   assign scan_done  = done_q;

endmodule
